// File: rtl/ex_stage_mem_reg.sv
// Execute stage with EX/MEM pipeline register and a shift-add signed multiplier.
// All state updates on the falling edge of CLK; RST is synchronous and active-high.
module ex_stage_mem_reg #(
   parameter int unsigned MUL_CYCLES = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [4:0]  Wreg_addr,
   input  logic [31:0] imm,
   input  logic [31:0] Rdata1,
   input  logic [31:0] Rdata2,
   input  logic [31:0] next_PC,
   input  logic        JtoPC,
   input  logic        Branch,
   input  logic        RegWrite,
   input  logic        ALUSrc,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic        MemtoReg,
   input  logic [3:0]  ALUOp,
   output logic        ex_stall,
   output logic [31:0] alu_result_4,
   output logic [31:0] store_data_4,
   output logic [4:0]  Wreg_addr_4,
   output logic        RegWrite_4,
   output logic        MemWrite_4,
   output logic        MemRead_4,
   output logic        MemtoReg_4,
   output logic        JtoPC_4,
   output logic        br_taken_4,
   output logic [31:0] br_target_4,
   output logic        valid_4
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1000;

   localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      mcand_q, mcand_d;
   logic [31:0]      mplier_q, mplier_d;
   logic             sign_q, sign_d;

   logic [31:0] alu_res_q, alu_res_d;
   logic [31:0] store_q, store_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        regw_q, regw_d, memw_q, memw_d, memr_q, memr_d;
   logic        m2r_q, m2r_d, jtopc_q, jtopc_d, brt_q, brt_d, valid_q, valid_d;
   logic [31:0] brtgt_q, brtgt_d;

   logic        is_mul;
   logic        wr_real;
   logic [31:0] opb;
   logic [31:0] alu_out;
   logic [31:0] mag_a, mag_b;
   logic [31:0] mul_out;

   assign is_mul  = (ALUOp == OP_MUL);
   assign opb     = ALUSrc ? imm : Rdata2;
   assign mag_a   = Rdata1[31] ? (~Rdata1 + 32'd1) : Rdata1;
   assign mag_b   = Rdata2[31] ? (~Rdata2 + 32'd1) : Rdata2;
   assign mul_out = sign_q ? (~acc_q + 32'd1) : acc_q;

   assign ex_stall = (state_q == RUN) || ((state_q == IDLE) && in_valid && is_mul);

   always_comb begin
      alu_out = '0;
      case (ALUOp)
         OP_AND:  alu_out = Rdata1 & opb;
         OP_OR:   alu_out = Rdata1 | opb;
         OP_ADD:  alu_out = Rdata1 + opb;
         OP_SUB:  alu_out = Rdata1 - opb;
         OP_SLT:  alu_out = {31'd0, ($signed(Rdata1) < $signed(opb))};
         OP_NOR:  alu_out = ~(Rdata1 | opb);
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      wr_real  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && is_mul) begin
               state_d  = RUN;
               mcand_d  = mag_a;
               mplier_d = mag_b;
               sign_d   = Rdata1[31] ^ Rdata2[31];
               acc_d    = '0;
               cnt_d    = '0;
            end else if (in_valid) begin
               wr_real = 1'b1;
            end
         end
         RUN: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            wr_real = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // flush overrides both a pending DONE write and a new issue
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         wr_real = 1'b0;
      end
   end

   always_comb begin
      alu_res_d = '0;
      store_d   = '0;
      waddr_d   = '0;
      regw_d    = 1'b0;
      memw_d    = 1'b0;
      memr_d    = 1'b0;
      m2r_d     = 1'b0;
      jtopc_d   = 1'b0;
      brt_d     = 1'b0;
      brtgt_d   = '0;
      valid_d   = 1'b0;
      if (wr_real) begin
         alu_res_d = (state_q == DONE) ? mul_out : alu_out;
         store_d   = Rdata2;
         waddr_d   = Wreg_addr;
         regw_d    = RegWrite;
         memw_d    = MemWrite;
         memr_d    = MemRead;
         m2r_d     = MemtoReg;
         jtopc_d   = JtoPC;
         brt_d     = Branch && (Rdata1 == Rdata2);
         brtgt_d   = next_PC + {imm[29:0], 2'b00};
         valid_d   = 1'b1;
      end
   end

   always_ff @(negedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         sign_q    <= 1'b0;
         alu_res_q <= '0;
         store_q   <= '0;
         waddr_q   <= '0;
         regw_q    <= 1'b0;
         memw_q    <= 1'b0;
         memr_q    <= 1'b0;
         m2r_q     <= 1'b0;
         jtopc_q   <= 1'b0;
         brt_q     <= 1'b0;
         brtgt_q   <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         sign_q    <= sign_d;
         alu_res_q <= alu_res_d;
         store_q   <= store_d;
         waddr_q   <= waddr_d;
         regw_q    <= regw_d;
         memw_q    <= memw_d;
         memr_q    <= memr_d;
         m2r_q     <= m2r_d;
         jtopc_q   <= jtopc_d;
         brt_q     <= brt_d;
         brtgt_q   <= brtgt_d;
         valid_q   <= valid_d;
      end
   end

   assign alu_result_4 = alu_res_q;
   assign store_data_4 = store_q;
   assign Wreg_addr_4  = waddr_q;
   assign RegWrite_4   = regw_q;
   assign MemWrite_4   = memw_q;
   assign MemRead_4    = memr_q;
   assign MemtoReg_4   = m2r_q;
   assign JtoPC_4      = jtopc_q;
   assign br_taken_4   = brt_q;
   assign br_target_4  = brtgt_q;
   assign valid_4      = valid_q;

endmodule
